// File: rtl/poly_bram_sequencer.sv
// BRAM-side mover for the polynomial register bank: streams one operand from BRAM
// into the bank input port, or drains the bank result register back into BRAM.
module poly_bram_sequencer #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_load_i,
  input  logic                  start_store_i,
  input  logic [1:0]            load_sel_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [WORD_WIDTH-1:0] bram_din_o,
  input  logic [WORD_WIDTH-1:0] bram_dout_i,
  output logic [1:0]            INPUT_reg_sel_o,
  output logic                  INPUT_reg_en_o,
  output logic [WORD_WIDTH-1:0] INPUT_reg_din_o,
  output logic                  RES_reg_shift_o,
  input  logic [WORD_WIDTH-1:0] RES_reg_dout_i
);

  localparam int WORDS = N * S;
  localparam int CNT_W = $clog2(WORDS + 1);

  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_MP0  = CNT_W'(N - 1);
  localparam logic [1:0]       SEL_MP0   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_LAST,
    ST_STORE,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        last_q, last_d;
  logic [1:0]              sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    last_word;

  // Natural truncation gives the modulo-2^ADDR_WIDTH wrap past the top address.
  assign cur_addr  = base_q + ADDR_WIDTH'(cnt_q);
  assign last_word = (cnt_q == last_q);

  // State and transfer latches
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      sel_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      base_q  <= base_d;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_d          = last_q;
    sel_d           = sel_q;
    base_d          = base_q;

    busy_o          = 1'b0;
    done_o          = 1'b0;
    bram_en_o       = 1'b0;
    bram_we_o       = 1'b0;
    bram_addr_o     = '0;
    bram_din_o      = '0;
    INPUT_reg_sel_o = '0;
    INPUT_reg_en_o  = 1'b0;
    INPUT_reg_din_o = '0;
    RES_reg_shift_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Load wins a simultaneous request; the store request is simply dropped.
        if (start_load_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          sel_d   = load_sel_i;
          base_d  = base_addr_i;
          last_d  = (load_sel_i == SEL_MP0) ? LAST_MP0 : LAST_FULL;
        end else if (start_store_i) begin
          state_d = ST_STORE;
          cnt_d   = '0;
          sel_d   = '0;
          base_d  = base_addr_i;
          last_d  = LAST_FULL;
        end
      end

      ST_LOAD: begin
        busy_o          = 1'b1;
        bram_en_o       = 1'b1;
        bram_addr_o     = cur_addr;
        INPUT_reg_sel_o = sel_q;
        // Read data lags the address by one cycle, so the first slot carries nothing.
        if (cnt_q != '0) begin
          INPUT_reg_en_o  = 1'b1;
          INPUT_reg_din_o = bram_dout_i;
        end
        if (last_word) begin
          state_d = ST_LOAD_LAST;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_LOAD_LAST: begin
        busy_o          = 1'b1;
        INPUT_reg_sel_o = sel_q;
        INPUT_reg_en_o  = 1'b1;
        INPUT_reg_din_o = bram_dout_i;
        state_d         = ST_DONE;
      end

      ST_STORE: begin
        busy_o          = 1'b1;
        bram_en_o       = 1'b1;
        bram_we_o       = 1'b1;
        bram_addr_o     = cur_addr;
        bram_din_o      = RES_reg_dout_i;
        RES_reg_shift_o = 1'b1;
        if (last_word) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
        sel_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_poly_bram_sequencer.sv
// Directed bench for poly_bram_sequencer with a latency-1 BRAM model and a
// shifting result-register model; per-cycle expectations are computed here.
module tb_poly_bram_sequencer;

  localparam int WW = 17;
  localparam int AW = 10;

  logic          clock_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          start_load_i = 1'b0;
  logic          start_store_i = 1'b0;
  logic [1:0]    load_sel_i = '0;
  logic [AW-1:0] base_addr_i = '0;
  logic          busy_o, done_o, bram_en_o, bram_we_o;
  logic [AW-1:0] bram_addr_o;
  logic [WW-1:0] bram_din_o;
  logic [WW-1:0] bram_dout_i = '0;
  logic [1:0]    INPUT_reg_sel_o;
  logic          INPUT_reg_en_o;
  logic [WW-1:0] INPUT_reg_din_o;
  logic          RES_reg_shift_o;
  logic [WW-1:0] RES_reg_dout_i;

  logic [WW-1:0] mem [0:1023];
  logic [WW-1:0] exp_word [0:19];
  int            res_k = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  poly_bram_sequencer #(.WORD_WIDTH(WW), .N(5), .S(4), .ADDR_WIDTH(AW)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .start_load_i(start_load_i), .start_store_i(start_store_i),
    .load_sel_i(load_sel_i), .base_addr_i(base_addr_i),
    .busy_o(busy_o), .done_o(done_o),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o),
    .bram_addr_o(bram_addr_o), .bram_din_o(bram_din_o), .bram_dout_i(bram_dout_i),
    .INPUT_reg_sel_o(INPUT_reg_sel_o), .INPUT_reg_en_o(INPUT_reg_en_o),
    .INPUT_reg_din_o(INPUT_reg_din_o),
    .RES_reg_shift_o(RES_reg_shift_o), .RES_reg_dout_i(RES_reg_dout_i)
  );

  always #5 clock_i = ~clock_i;

  // BRAM model, read latency 1
  always @(posedge clock_i) begin
    if (bram_en_o && bram_we_o) mem[bram_addr_o] <= bram_din_o;
    if (bram_en_o && !bram_we_o) bram_dout_i <= mem[bram_addr_o];
  end

  // Result register model: presents 0x100+k, advancing on each shift
  always @(posedge clock_i) if (RES_reg_shift_o) res_k <= res_k + 1;
  assign RES_reg_dout_i = WW'(32'h100 + res_k);

  task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},  32'(busy_o), 0);
    check_val({tag, "_done"},  32'(done_o), 0);
    check_val({tag, "_en"},    32'(bram_en_o), 0);
    check_val({tag, "_we"},    32'(bram_we_o), 0);
    check_val({tag, "_addr"},  32'(bram_addr_o), 0);
    check_val({tag, "_bdin"},  32'(bram_din_o), 0);
    check_val({tag, "_isel"},  32'(INPUT_reg_sel_o), 0);
    check_val({tag, "_ien"},   32'(INPUT_reg_en_o), 0);
    check_val({tag, "_idin"},  32'(INPUT_reg_din_o), 0);
    check_val({tag, "_shift"}, 32'(RES_reg_shift_o), 0);
  endtask

  task automatic preload(input int base, input int w, input int first);
    for (int k = 0; k < w; k++) begin
      exp_word[k] = WW'(first + k);
      mem[(base + k) % 1024] = WW'(first + k);
    end
  endtask

  task automatic run_load(input string tag, input logic [1:0] sel, input int base, input int w,
                          input bit both, input bit mid_store);
    int n_ien;
    n_ien = 0;
    @(negedge clock_i);
    load_sel_i = sel; base_addr_i = AW'(base); start_load_i = 1'b1; start_store_i = both;
    @(posedge clock_i); #1;
    start_load_i = 1'b0; start_store_i = 1'b0; load_sel_i = 2'd0; base_addr_i = '0;
    for (int c = 1; c <= w + 2; c++) begin
      @(negedge clock_i);
      if (c == 6) start_store_i = 1'b0;
      check_val({tag, "_en"},   32'(bram_en_o), (c <= w) ? 1 : 0);
      check_val({tag, "_we"},   32'(bram_we_o), 0);
      check_val({tag, "_addr"}, 32'(bram_addr_o), (c <= w) ? (base + c - 1) % 1024 : 0);
      check_val({tag, "_ien"},  32'(INPUT_reg_en_o), (c >= 2 && c <= w + 1) ? 1 : 0);
      check_val({tag, "_idin"}, 32'(INPUT_reg_din_o),
                (c >= 2 && c <= w + 1) ? 32'(exp_word[c - 2]) : 0);
      check_val({tag, "_isel"}, 32'(INPUT_reg_sel_o), (c <= w + 1) ? 32'(sel) : 0);
      check_val({tag, "_busy"}, 32'(busy_o), (c <= w + 1) ? 1 : 0);
      check_val({tag, "_done"}, 32'(done_o), (c == w + 2) ? 1 : 0);
      check_val({tag, "_shift"}, 32'(RES_reg_shift_o), 0);
      if (INPUT_reg_en_o) n_ien++;
      if (mid_store && c == 5) start_store_i = 1'b1;
    end
    check_val({tag, "_ien_count"}, 32'(n_ien), 32'(w));
  endtask

  task automatic run_store(input string tag, input int base);
    int k0;
    k0 = res_k;
    @(negedge clock_i);
    base_addr_i = AW'(base); start_store_i = 1'b1;
    @(posedge clock_i); #1;
    start_store_i = 1'b0; base_addr_i = '0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clock_i);
      check_val({tag, "_en"},    32'(bram_en_o), (c <= 20) ? 1 : 0);
      check_val({tag, "_we"},    32'(bram_we_o), (c <= 20) ? 1 : 0);
      check_val({tag, "_addr"},  32'(bram_addr_o), (c <= 20) ? (base + c - 1) % 1024 : 0);
      check_val({tag, "_bdin"},  32'(bram_din_o), (c <= 20) ? 32'h100 + c - 1 : 0);
      check_val({tag, "_shift"}, 32'(RES_reg_shift_o), (c <= 20) ? 1 : 0);
      check_val({tag, "_ien"},   32'(INPUT_reg_en_o), 0);
      check_val({tag, "_busy"},  32'(busy_o), (c <= 20) ? 1 : 0);
      check_val({tag, "_done"},  32'(done_o), (c == 21) ? 1 : 0);
    end
    check_val({tag, "_shift_count"}, 32'(res_k - k0), 20);
    for (int k = 0; k < 20; k++)
      check_val({tag, "_mem"}, 32'(mem[(base + k) % 1024]), 32'h100 + k);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clock_i);
    check_idle_outputs("reset");
    reset_n_i = 1'b1;
    @(negedge clock_i);
    check_idle_outputs("idle");

    // 1: load A
    preload(32'h010, 20, 1);
    run_load("loadA", 2'd0, 32'h010, 20, 1'b0, 1'b0);

    // 2: load M_prime_0 with address wrap
    preload(32'h3FE, 5, 32'h1ABC0);
    run_load("loadMP0", 2'd3, 32'h3FE, 5, 1'b0, 1'b0);

    // 3: store result register
    run_store("store", 32'h200);

    // 4: simultaneous starts run only the B load; mid-load store ignored
    preload(32'h080, 20, 32'h500);
    run_load("loadB_both", 2'd1, 32'h080, 20, 1'b1, 1'b1);
    @(negedge clock_i);
    check_idle_outputs("after_both");

    // 5: reset mid-load aborts at once with no done
    preload(32'h010, 20, 1);
    @(negedge clock_i);
    load_sel_i = 2'd0; base_addr_i = AW'(32'h010); start_load_i = 1'b1;
    @(posedge clock_i); #1;
    start_load_i = 1'b0; base_addr_i = '0;
    for (int c = 1; c <= 8; c++) @(negedge clock_i);
    check_val("pre_abort_busy", 32'(busy_o), 1);
    reset_n_i = 1'b0;
    #1;
    check_idle_outputs("abort");
    for (int c = 0; c < 3; c++) begin
      @(negedge clock_i);
      check_val("abort_done", 32'(done_o), 0);
      check_val("abort_en", 32'(bram_en_o), 0);
    end
    reset_n_i = 1'b1;
    @(negedge clock_i);
    check_idle_outputs("post_reset");
    preload(32'h040, 20, 32'h700);
    run_load("loadB_after_reset", 2'd1, 32'h040, 20, 1'b0, 1'b0);

    // 6: back-to-back loads, the second started the cycle after done
    preload(32'h100, 20, 32'h900);
    run_load("b2b_B", 2'd1, 32'h100, 20, 1'b0, 1'b0);
    preload(32'h150, 20, 32'h1000);
    run_load("b2b_M", 2'd2, 32'h150, 20, 1'b0, 1'b0);
    @(negedge clock_i);
    check_idle_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
